// File: rtl/wb_burst_master.sv
// Wishbone burst initiator: turns one (address, length, direction) command into
// single or incrementing-burst Wishbone cycles, streaming write data in and read data out.
module wb_burst_master #(
    parameter int unsigned Dw      = 32,
    parameter int unsigned Aw      = 32,
    parameter int unsigned SELw    = 4,
    parameter int unsigned TAGw    = 3,
    parameter int unsigned CTIw    = 3,
    parameter int unsigned BTEw    = 2,
    parameter int unsigned LENw    = 8,
    parameter int unsigned MAX_RTY = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic            cmd_we,
    input  logic [Aw-1:0]   cmd_adr,
    input  logic [LENw-1:0] cmd_len,
    input  logic [Dw-1:0]   wr_dat,
    input  logic            wr_valid,
    output logic            wr_ready,
    output logic [Dw-1:0]   rd_dat,
    output logic            rd_valid,
    output logic            done,
    output logic            done_err,
    output logic [Aw-1:0]   m_adr_o,
    output logic [Dw-1:0]   m_dat_o,
    output logic [SELw-1:0] m_sel_o,
    output logic [TAGw-1:0] m_tag_o,
    output logic            m_we_o,
    output logic            m_stb_o,
    output logic            m_cyc_o,
    output logic [CTIw-1:0] m_cti_o,
    output logic [BTEw-1:0] m_bte_o,
    input  logic [Dw-1:0]   m_dat_i,
    input  logic            m_ack_i,
    input  logic            m_err_i,
    input  logic            m_rty_i
);

    localparam int unsigned RCw = $clog2(MAX_RTY + 1);

    localparam logic [CTIw-1:0] CTI_CLASSIC = CTIw'(0);
    localparam logic [CTIw-1:0] CTI_INCR    = CTIw'(2);
    localparam logic [CTIw-1:0] CTI_EOB     = CTIw'(7);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_BUS,
        S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [Aw-1:0]     adr_q, adr_d;
    logic [Dw-1:0]     dat_q, dat_d;
    logic              we_q, we_d;
    logic              stb_q, stb_d;
    logic              cyc_q, cyc_d;
    logic [CTIw-1:0]   cti_q, cti_d;
    logic [Dw-1:0]     rd_dat_q, rd_dat_d;
    logic              rd_valid_q, rd_valid_d;
    logic              done_q, done_d;
    logic              done_err_q, done_err_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic              wr_ready_q, wr_ready_d;
    logic [LENw-1:0]   beats_left_q, beats_left_d;
    logic [RCw-1:0]    rty_cnt_q, rty_cnt_d;
    logic              finish, finish_err;

    // Next-state and registered-output computation
    always_comb begin
        state_d      = state_q;
        adr_d        = adr_q;
        dat_d        = dat_q;
        we_d         = we_q;
        stb_d        = stb_q;
        cyc_d        = cyc_q;
        cti_d        = cti_q;
        rd_dat_d     = rd_dat_q;
        rd_valid_d   = 1'b0;
        done_d       = 1'b0;
        done_err_d   = 1'b0;
        cmd_ready_d  = cmd_ready_q;
        wr_ready_d   = wr_ready_q;
        beats_left_d = beats_left_q;
        rty_cnt_d    = rty_cnt_q;
        finish       = 1'b0;
        finish_err   = 1'b0;

        case (state_q)
            S_IDLE: begin
                cmd_ready_d = 1'b1;
                if (cmd_valid && cmd_ready_q) begin
                    cmd_ready_d  = 1'b0;
                    adr_d        = cmd_adr;
                    we_d         = cmd_we;
                    beats_left_d = cmd_len;
                    rty_cnt_d    = '0;
                    cyc_d        = 1'b1;
                    cti_d        = (cmd_len == '0) ? CTI_CLASSIC : CTI_INCR;
                    if (cmd_we) begin
                        state_d    = S_LOAD;
                        stb_d      = 1'b0;
                        wr_ready_d = 1'b1;
                    end else begin
                        state_d = S_BUS;
                        stb_d   = 1'b1;
                    end
                end
            end

            S_LOAD: begin
                if (wr_valid && wr_ready_q) begin
                    dat_d      = wr_dat;
                    wr_ready_d = 1'b0;
                    stb_d      = 1'b1;
                    state_d    = S_BUS;
                end
            end

            S_BUS: begin
                // stb low here only for the one-cycle gap after a retry
                if (!stb_q) begin
                    stb_d = 1'b1;
                end else if (m_err_i) begin
                    finish     = 1'b1;
                    finish_err = 1'b1;
                end else if (m_rty_i) begin
                    if (rty_cnt_q == RCw'(MAX_RTY - 1)) begin
                        finish     = 1'b1;
                        finish_err = 1'b1;
                    end else begin
                        rty_cnt_d = rty_cnt_q + RCw'(1);
                        stb_d     = 1'b0;
                    end
                end else if (m_ack_i) begin
                    adr_d     = adr_q + Aw'(SELw);
                    rty_cnt_d = '0;
                    if (!we_q) begin
                        rd_dat_d   = m_dat_i;
                        rd_valid_d = 1'b1;
                    end
                    if (beats_left_q == '0) begin
                        finish = 1'b1;
                    end else begin
                        beats_left_d = beats_left_q - LENw'(1);
                        cti_d        = (beats_left_q == LENw'(1)) ? CTI_EOB : CTI_INCR;
                        if (we_q) begin
                            state_d    = S_LOAD;
                            stb_d      = 1'b0;
                            wr_ready_d = 1'b1;
                        end
                    end
                end
            end

            S_DONE: begin
                state_d     = S_IDLE;
                cmd_ready_d = 1'b1;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Common command termination: release the bus and pulse done
        if (finish) begin
            state_d    = S_DONE;
            cyc_d      = 1'b0;
            stb_d      = 1'b0;
            we_d       = 1'b0;
            cti_d      = CTI_CLASSIC;
            wr_ready_d = 1'b0;
            done_d     = 1'b1;
            done_err_d = finish_err;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            adr_q        <= '0;
            dat_q        <= '0;
            we_q         <= 1'b0;
            stb_q        <= 1'b0;
            cyc_q        <= 1'b0;
            cti_q        <= '0;
            rd_dat_q     <= '0;
            rd_valid_q   <= 1'b0;
            done_q       <= 1'b0;
            done_err_q   <= 1'b0;
            cmd_ready_q  <= 1'b0;
            wr_ready_q   <= 1'b0;
            beats_left_q <= '0;
            rty_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            adr_q        <= adr_d;
            dat_q        <= dat_d;
            we_q         <= we_d;
            stb_q        <= stb_d;
            cyc_q        <= cyc_d;
            cti_q        <= cti_d;
            rd_dat_q     <= rd_dat_d;
            rd_valid_q   <= rd_valid_d;
            done_q       <= done_d;
            done_err_q   <= done_err_d;
            cmd_ready_q  <= cmd_ready_d;
            wr_ready_q   <= wr_ready_d;
            beats_left_q <= beats_left_d;
            rty_cnt_q    <= rty_cnt_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign wr_ready  = wr_ready_q;
    assign rd_dat    = rd_dat_q;
    assign rd_valid  = rd_valid_q;
    assign done      = done_q;
    assign done_err  = done_err_q;
    assign m_adr_o   = adr_q;
    assign m_dat_o   = dat_q;
    assign m_we_o    = we_q;
    assign m_stb_o   = stb_q;
    assign m_cyc_o   = cyc_q;
    assign m_cti_o   = cti_q;
    assign m_sel_o   = {SELw{1'b1}};
    assign m_tag_o   = '0;
    assign m_bte_o   = '0;

endmodule

// File: tb/tb_wb_burst_master.sv
// Scoreboard bench for wb_burst_master: a scripted Wishbone slave answers each
// strobe, and independent monitors check bus beats, read data and done pulses.
module tb_wb_burst_master;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid, cmd_ready, cmd_we;
    logic [31:0] cmd_adr;
    logic [7:0]  cmd_len;
    logic [31:0] wr_dat;
    logic        wr_valid, wr_ready;
    logic [31:0] rd_dat;
    logic        rd_valid, done, done_err;
    logic [31:0] m_adr_o, m_dat_o, m_dat_i;
    logic [3:0]  m_sel_o;
    logic [2:0]  m_tag_o, m_cti_o;
    logic [1:0]  m_bte_o;
    logic        m_we_o, m_stb_o, m_cyc_o, m_ack_i, m_err_i, m_rty_i;

    wb_burst_master dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_adr(cmd_adr), .cmd_len(cmd_len),
        .wr_dat(wr_dat), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_dat(rd_dat), .rd_valid(rd_valid), .done(done), .done_err(done_err),
        .m_adr_o(m_adr_o), .m_dat_o(m_dat_o), .m_sel_o(m_sel_o), .m_tag_o(m_tag_o),
        .m_we_o(m_we_o), .m_stb_o(m_stb_o), .m_cyc_o(m_cyc_o), .m_cti_o(m_cti_o),
        .m_bte_o(m_bte_o), .m_dat_i(m_dat_i), .m_ack_i(m_ack_i), .m_err_i(m_err_i),
        .m_rty_i(m_rty_i)
    );

    always #5 clk = ~clk;

    localparam int K_ACK = 0, K_ERR = 1, K_RTY = 2, K_ERRACK = 3;

    typedef struct {
        int unsigned wt;
        int          kind;
        logic [31:0] rdat;
    } rsp_t;

    typedef struct packed {
        logic [31:0] adr;
        logic        we;
        logic [31:0] dat;
        logic [2:0]  cti;
    } beat_t;

    rsp_t        rsp_q[$];
    beat_t       beat_q[$];
    logic [31:0] rd_q[$];
    logic        done_q[$];

    int n_checks = 0, n_pass = 0;
    int slave_cnt = 0, done_cnt = 0, rd_cnt = 0, gap = 0;
    bit busy = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h required %0h", name, act, exp);
    endtask

    task automatic fail(input string name);
        n_checks++;
        $display("FAIL %s: event or timeout not allowed here", name);
    endtask

    // Scripted slave: answers the head response after its wait count of strobed cycles
    initial begin
        m_ack_i = 1'b0; m_err_i = 1'b0; m_rty_i = 1'b0; m_dat_i = '0;
        forever begin
            @(negedge clk);
            m_ack_i = 1'b0; m_err_i = 1'b0; m_rty_i = 1'b0;
            if (m_cyc_o && m_stb_o && rsp_q.size() > 0) begin
                if (slave_cnt >= int'(rsp_q[0].wt)) begin
                    m_dat_i = rsp_q[0].rdat;
                    m_ack_i = (rsp_q[0].kind == K_ACK) || (rsp_q[0].kind == K_ERRACK);
                    m_err_i = (rsp_q[0].kind == K_ERR) || (rsp_q[0].kind == K_ERRACK);
                    m_rty_i = (rsp_q[0].kind == K_RTY);
                    void'(rsp_q.pop_front());
                    slave_cnt = 0;
                end else begin
                    slave_cnt++;
                end
            end
        end
    end

    // Bus-beat monitor: every responded strobe must match the next expected beat
    initial forever begin
        @(negedge clk); #1;
        if (m_cyc_o && m_stb_o && (m_ack_i || m_err_i || m_rty_i)) begin
            if (beat_q.size() == 0) fail("beat_unexpected");
            else begin
                beat_t e;
                e = beat_q.pop_front();
                chk("beat", {m_adr_o, m_we_o, (e.we ? m_dat_o : 32'h0), m_cti_o, m_sel_o, m_tag_o, m_bte_o},
                    {e.adr, e.we, e.dat, e.cti, 4'hF, 3'h0, 2'h0});
            end
        end
    end

    // Read-data monitor
    initial forever begin
        @(negedge clk);
        if (rd_valid) begin
            if (rd_q.size() == 0) fail("rd_unexpected");
            else chk("rd_dat", rd_dat, rd_q.pop_front());
            rd_cnt++;
        end
    end

    // Done monitor: bus must already be released when done pulses
    initial forever begin
        @(negedge clk);
        if (done) begin
            if (done_q.size() == 0) fail("done_unexpected");
            else chk("done_err_cyc_stb", {done_err, m_cyc_o, m_stb_o}, {done_q.pop_front(), 2'b00});
            done_cnt++;
            busy = 1'b0;
        end
    end

    // CYC continuity inside a command
    initial forever begin
        @(negedge clk); #1;
        if (busy && !m_cyc_o && !done) gap++;
    end

    task automatic add_beat(input int unsigned wt, input int kind, input logic [31:0] rdat,
                            input logic [31:0] adr, input logic we, input logic [31:0] wdat,
                            input logic [2:0] cti);
        rsp_t  r;
        beat_t b;
        r.wt = wt; r.kind = kind; r.rdat = rdat;
        b.adr = adr; b.we = we; b.dat = we ? wdat : 32'h0; b.cti = cti;
        rsp_q.push_back(r);
        beat_q.push_back(b);
    endtask

    task automatic issue_cmd(input logic we, input logic [31:0] adr, input logic [7:0] len);
        int t;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_len = len;
        t = 0;
        while (!cmd_ready && t < 50) begin @(negedge clk); t++; end
        if (t >= 50) fail("cmd_accept_timeout");
        @(posedge clk);
        busy = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic feed_wr(input logic [31:0] d, input int dly);
        int t;
        t = 0;
        while (!wr_ready && t < 200) begin @(negedge clk); t++; end
        if (t >= 200) fail("wr_ready_timeout");
        for (int i = 0; i < dly; i++) begin
            chk("stall_cyc_stb_wrrdy", {m_cyc_o, m_stb_o, wr_ready}, 3'b101);
            @(negedge clk);
        end
        wr_dat = d; wr_valid = 1'b1;
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int target, t;
        target = done_cnt + 1;
        t = 0;
        while (done_cnt < target && t < 500) begin @(negedge clk); t++; end
        if (t >= 500) fail("done_timeout");
        @(negedge clk); #2;
        chk({name, "_queues_empty"}, {beat_q.size(), rd_q.size(), done_q.size(), rsp_q.size()}, 128'h0);
        chk({name, "_cyc_gap"}, gap, 0);
        gap = 0;
    endtask

    initial begin
        int t, base_done;
        reset = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_len = '0;
        wr_dat = '0; wr_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ctrl", {m_cyc_o, m_stb_o, m_we_o, cmd_ready, rd_valid, done, done_err, wr_ready}, 8'h00);
        chk("rst_data", {m_adr_o, m_dat_o, rd_dat, m_cti_o}, 99'h0);
        reset = 1'b0;
        @(negedge clk);
        chk("cmd_ready_after_reset", cmd_ready, 1'b1);

        // Single write, slave waits 2 cycles
        add_beat(2, K_ACK, 0, 32'h100, 1'b1, 32'hDEADBEEF, 3'b000);
        done_q.push_back(1'b0);
        issue_cmd(1'b1, 32'h100, 8'd0);
        feed_wr(32'hDEADBEEF, 0);
        wait_done("single_write");

        // 4-beat read burst, ack every cycle
        for (int i = 0; i < 4; i++) begin
            add_beat(0, K_ACK, 32'(i + 1), 32'h200 + 32'(4 * i), 1'b0, 0, (i == 3) ? 3'b111 : 3'b010);
            rd_q.push_back(32'(i + 1));
        end
        done_q.push_back(1'b0);
        issue_cmd(1'b0, 32'h200, 8'd3);
        wait_done("read_burst");

        // 3-beat write, beat 2 data withheld 5 cycles
        for (int i = 0; i < 3; i++)
            add_beat(1, K_ACK, 0, 32'h300 + 32'(4 * i), 1'b1, 32'hA0 + 32'(i), (i == 2) ? 3'b111 : 3'b010);
        done_q.push_back(1'b0);
        issue_cmd(1'b1, 32'h300, 8'd2);
        feed_wr(32'hA0, 0);
        feed_wr(32'hA1, 5);
        feed_wr(32'hA2, 0);
        wait_done("write_stall");

        // Err together with ack on beat 2: err wins
        add_beat(0, K_ACK, 32'h11, 32'h400, 1'b0, 0, 3'b010);
        add_beat(0, K_ERRACK, 32'h22, 32'h404, 1'b0, 0, 3'b010);
        rd_q.push_back(32'h11);
        done_q.push_back(1'b1);
        issue_cmd(1'b0, 32'h400, 8'd3);
        wait_done("err_abort");

        // Three retries then ack
        for (int i = 0; i < 4; i++)
            add_beat(0, (i == 3) ? K_ACK : K_RTY, 32'h55, 32'h500, 1'b0, 0, 3'b000);
        rd_q.push_back(32'h55);
        done_q.push_back(1'b0);
        issue_cmd(1'b0, 32'h500, 8'd0);
        wait_done("retry_ok");

        // Four retries exhaust the limit
        for (int i = 0; i < 4; i++)
            add_beat(0, K_RTY, 0, 32'h504, 1'b1, 32'hCAFEF00D, 3'b000);
        done_q.push_back(1'b1);
        issue_cmd(1'b1, 32'h504, 8'd0);
        feed_wr(32'hCAFEF00D, 0);
        wait_done("retry_abort");

        // Address wrap at the top of the space
        add_beat(0, K_ACK, 32'hA, 32'hFFFF_FFFC, 1'b0, 0, 3'b010);
        add_beat(0, K_ACK, 32'hB, 32'h0000_0000, 1'b0, 0, 3'b111);
        rd_q.push_back(32'hA);
        rd_q.push_back(32'hB);
        done_q.push_back(1'b0);
        issue_cmd(1'b0, 32'hFFFF_FFFC, 8'd1);
        wait_done("addr_wrap");

        // Reset in the middle of a 4-beat read
        add_beat(0, K_ACK, 32'h61, 32'h600, 1'b0, 0, 3'b010);
        rsp_q.push_back('{wt: 1000, kind: K_ACK, rdat: 32'h62});
        rd_q.push_back(32'h61);
        base_done = done_cnt;
        issue_cmd(1'b0, 32'h600, 8'd3);
        t = 0;
        while (rd_cnt == 0 && t < 100) begin @(negedge clk); #1; t++; end
        t = 0;
        while (rd_q.size() != 0 && t < 100) begin @(negedge clk); #1; t++; end
        if (t >= 100) fail("mid_burst_rd_timeout");
        #1;
        busy = 1'b0;
        reset = 1'b1;
        #1;
        chk("reset_drops_bus", {m_cyc_o, m_stb_o}, 2'b00);
        rsp_q.delete();
        beat_q.delete();
        slave_cnt = 0;
        repeat (3) @(negedge clk);
        chk("reset_no_done", {32'(done_cnt), 1'b0, done}, {32'(base_done), 1'b0, 1'b0});
        reset = 1'b0;

        add_beat(0, K_ACK, 32'h71, 32'h700, 1'b0, 0, 3'b010);
        add_beat(0, K_ACK, 32'h72, 32'h704, 1'b0, 0, 3'b111);
        rd_q.push_back(32'h71);
        rd_q.push_back(32'h72);
        done_q.push_back(1'b0);
        issue_cmd(1'b0, 32'h700, 8'd1);
        wait_done("after_reset");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

endmodule
